// File: rtl/alu_32_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_32_mc
// Description : 32-bit multi-cycle ALU. Logic/arithmetic ops finish in one
//               execute cycle; MUL is a 32-step shift-add. Results are held
//               in registers and flagged by a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_32_mc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [1:0]  r_state;
    logic [3:0]  r_op;
    logic [31:0] r_a;       // operand A; doubles as the shifting multiplicand
    logic [31:0] r_b;       // operand B; doubles as the shifting multiplier
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_exec_res;
    logic        w_exec_ov;
    logic [31:0] w_mul_step;

    assign ready = (r_state == S_IDLE);

    // Single-cycle datapath on the latched operands, plus one shift-add step.
    always_comb begin
        w_sum      = r_a + r_b;
        w_diff     = r_a - r_b;
        w_exec_res = 32'd0;
        w_exec_ov  = 1'b0;
        w_mul_step = r_acc + (r_b[0] ? r_a : 32'd0);
        case (r_op)
            OP_AND: w_exec_res = r_a & r_b;
            OP_OR:  w_exec_res = r_a | r_b;
            OP_ADD: begin
                w_exec_res = w_sum;
                w_exec_ov  = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
            end
            OP_XOR: w_exec_res = r_a ^ r_b;
            OP_SRL: w_exec_res = r_b >> r_a[4:0];
            OP_SUB: begin
                w_exec_res = w_diff;
                w_exec_ov  = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
            end
            OP_SLT: w_exec_res = {31'd0, ($signed(r_a) < $signed(r_b))};
            OP_NOR: w_exec_res = ~(r_a | r_b);
            default: begin
                w_exec_res = 32'd0;
                w_exec_ov  = 1'b0;
            end
        endcase
    end

    // Control FSM and result registers; outputs only move when done fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd0;
            done     <= 1'b0;
            result   <= 32'd0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= num1;
                        r_b   <= num2;
                        r_acc <= 32'd0;
                        r_cnt <= 6'd0;
                        r_state <= (op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result   <= w_exec_res;
                    zero     <= (w_exec_res == 32'd0);
                    overflow <= w_exec_ov;
                    done     <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    r_acc <= w_mul_step;
                    r_a   <= {r_a[30:0], 1'b0};
                    r_b   <= {1'b0, r_b[31:1]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        result   <= w_mul_step;
                        zero     <= (w_mul_step == 32'd0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_32_mc.md
ALU_32_MC -- requirements
Module: alu_32_mc

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Reset, synchronous, active-low: sampled only on the rising clk edge, asserted when 0.
REQ-004 start  input  1  Request strobe; accepted only when ready=1.
REQ-005 op  input  4  Operation select, sampled with start.
REQ-006 num1  input  32  Operand A, sampled with start.
REQ-007 num2  input  32  Operand B, sampled with start.
REQ-008 ready  output  1  High when idle and able to accept start.
REQ-009 done  output  1  One-cycle pulse marking result, zero and overflow valid.
REQ-010 result  output  32  Registered result; held until the next done.
REQ-011 zero  output  1  Registered; 1 when result==0, updated with done.
REQ-012 overflow  output  1  Registered signed overflow for ADD/SUB; 0 for all other ops.

Function
REQ-013 Op encoding SHALL be: 0000 AND (bitwise num1&num2), 0001 OR, 0010 ADD, 0011 XOR, 0100 SRL (num2 >> num1[4:0], zero fill), 0110 SUB (num1-num2), 0111 SLT (signed num1<num2 gives 1, else 0), 1000 MUL (low 32 bits of unsigned num1*num2), 1100 NOR.
REQ-014 Undefined op codes SHALL complete as single-cycle ops with result=0, overflow=0, zero=1.
REQ-015 FSM states SHALL be IDLE, EXEC, MUL, DONE; the reset state SHALL be IDLE.
REQ-016 IDLE: ready=1; start=1 SHALL latch op/num1/num2 and go to MUL if op==1000, otherwise to EXEC.
REQ-017 EXEC: SHALL compute the selected op on the latched operands, register result/zero/overflow, and go to DONE.
REQ-018 MUL: SHALL perform a shift-add over exactly 32 iterations (one multiplier bit per cycle, LSB first), with a 6-bit counter, then register result/zero and go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; ready=0 in DONE.
REQ-020 Latency, start edge to done=1: single-cycle ops 2 cycles; MUL 33 cycles.
REQ-021 ready SHALL be 0 in EXEC, MUL and DONE; start in those states SHALL be ignored, with no queuing.
REQ-022 Back-to-back: start asserted in the IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of 3 cycles for single-cycle ops.
REQ-023 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-024 ADD/SUB overflow SHALL be the signed rule: operand signs agree (SUB: differ) and the result sign differs from num1.
REQ-025 ADD/SUB SHALL wrap modulo 2^32; MUL SHALL discard the upper 32 product bits and set overflow=0.
REQ-026 SRL with num1[4:0]=0 SHALL return num2 unchanged; num1[31:5] SHALL be ignored.
REQ-027 result/zero/overflow SHALL change only on the cycle done asserts (or on reset).

Reset
REQ-028 With rst_n=0 at a clk edge, the block SHALL enter IDLE with ready=1, done=0, result=0, zero=1, overflow=0, and the MUL counter and accumulator cleared.
REQ-029 Reset asserted in any state, including mid-MUL, SHALL abort the operation with no done pulse; start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 AND: op=0000, num1=0xF0F0_1234, num2=0x0FF0_FFFF -> done at cycle 2, result=0x00F0_1234, zero=0.
REQ-031 ADD overflow: op=0010, 0x7FFF_FFFF + 0x0000_0001 -> result=0x8000_0000, overflow=1; SUB 5-5 -> result=0, zero=1, overflow=0.
REQ-032 SLT signed: num1=0xFFFF_FFFF (-1), num2=1 -> result=1; operands swapped -> result=0.
REQ-033 MUL: 0x0001_0003 * 0x0000_0005 -> done exactly 33 cycles after start, result=0x0005_000F; start pulses while busy are ignored.
REQ-034 Reset mid-MUL: rst_n=0 at iteration 10 -> no done pulse, ready=1, result=0 next cycle; a following AND completes correctly.
REQ-035 Back-to-back: an OR issued on the first IDLE cycle after DONE is accepted, and its done arrives 2 cycles later.
